// File: rtl/mcac_pkg.sv
// Shared constants and types for the MCAC TDM transmit path.
package mcac_pkg;

    localparam int unsigned NUM_CH = 32;
    localparam int unsigned SLOT_W = 8;
    localparam logic [SLOT_W-1:0] IDLE_CODE = 8'hFF;

    typedef enum logic {IDLE, SEND} tdm_tx_state_t;

    typedef logic [SLOT_W-1:0] pcm_word_t;

endpackage

// File: rtl/mcac_tdm_frame_buf.sv
// Two-bank PCM frame buffer: the core fills one bank while the other is serialized.
// The read port looks at the bank that will be transmitting after the current edge.
module mcac_tdm_frame_buf #(
    parameter int unsigned NUM_CH = 32,
    parameter int unsigned SLOT_W = 8,
    parameter logic [SLOT_W-1:0] IDLE_CODE = 8'hFF
) (
    input  logic                      clk_i,
    input  logic                      rst_ni,
    input  logic                      swap_i,
    input  logic                      wr_en_i,
    input  logic [$clog2(NUM_CH)-1:0] wr_ch_i,
    input  logic [SLOT_W-1:0]         wr_data_i,
    input  logic [$clog2(NUM_CH)-1:0] rd_ch_i,
    output logic [SLOT_W-1:0]         rd_word_o,
    output logic                      rd_valid_o
);

    logic                         bank_sel_q;
    logic [1:0][NUM_CH-1:0]       valid_q, valid_d;
    logic [SLOT_W-1:0]            mem_q [2][NUM_CH];
    logic                         wr_bank;
    logic                         rd_bank;

    // On a swap edge the old transmit bank becomes the fill bank, so writes follow it.
    assign wr_bank = swap_i ? bank_sel_q : ~bank_sel_q;
    assign rd_bank = swap_i ? ~bank_sel_q : bank_sel_q;

    always_comb begin
        valid_d = valid_q;
        if (swap_i) begin
            valid_d[bank_sel_q] = '0;
        end
        if (wr_en_i) begin
            valid_d[wr_bank][wr_ch_i] = 1'b1;
        end
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            bank_sel_q <= 1'b0;
            valid_q    <= '0;
        end else begin
            valid_q <= valid_d;
            if (swap_i) begin
                bank_sel_q <= ~bank_sel_q;
            end
        end
    end

    always_ff @(posedge clk_i) begin
        if (wr_en_i) begin
            mem_q[wr_bank][wr_ch_i] <= wr_data_i;
        end
    end

    assign rd_valid_o = valid_q[rd_bank][rd_ch_i];
    assign rd_word_o  = rd_valid_o ? mem_q[rd_bank][rd_ch_i] : IDLE_CODE;

endmodule

// File: rtl/mcac_tdm_tx.sv
// Serial TDM transmitter: shifts one PCM word per slot MSB-first, aligned to frame sync.
// Holds the slot/bit counters and registered serial outputs; storage lives in the frame buffer.
module mcac_tdm_tx #(
    parameter int unsigned NUM_CH = mcac_pkg::NUM_CH,
    parameter int unsigned SLOT_W = mcac_pkg::SLOT_W,
    parameter logic [SLOT_W-1:0] IDLE_CODE = mcac_pkg::IDLE_CODE
) (
    input  logic                      clk_i,
    input  logic                      rst_ni,
    input  logic                      bit_en_i,
    input  logic                      fs_i,
    input  logic                      wr_en_i,
    input  logic [$clog2(NUM_CH)-1:0] wr_ch_i,
    input  logic [SLOT_W-1:0]         wr_data_i,
    output logic                      tx_data_o,
    output logic                      tx_oe_o,
    output logic                      frame_start_o,
    output logic [$clog2(NUM_CH)-1:0] slot_ch_o,
    output logic                      underrun_o,
    output logic                      wr_err_o,
    output logic                      fs_err_o
);

    import mcac_pkg::*;

    localparam int unsigned ChW  = $clog2(NUM_CH);
    localparam int unsigned BitW = (SLOT_W > 1) ? $clog2(SLOT_W) : 1;
    localparam logic [ChW-1:0]  LastCh  = ChW'(NUM_CH - 1);
    localparam logic [BitW-1:0] LastBit = BitW'(SLOT_W - 1);

    tdm_tx_state_t     state_q;
    logic [ChW-1:0]    slot_ch_q;
    logic [BitW-1:0]   bit_cnt_q;
    logic              tx_data_q, tx_oe_q, frame_start_q, underrun_q, wr_err_q, fs_err_q;

    logic              frame_go;
    logic              frame_done;
    logic              wr_bad;
    logic              wr_ok;
    logic [ChW-1:0]    rd_ch;
    logic [SLOT_W-1:0] rd_word;
    logic              rd_valid;

    assign frame_go   = bit_en_i && fs_i;
    assign frame_done = (bit_cnt_q == '0) && (slot_ch_q == LastCh);

    // Out-of-range channels only exist when NUM_CH is not a power of two.
    if ((1 << ChW) > NUM_CH) begin : g_range_chk
        assign wr_bad = wr_en_i && (32'(wr_ch_i) >= NUM_CH);
    end else begin : g_no_range_chk
        assign wr_bad = 1'b0;
    end
    assign wr_ok = wr_en_i && !wr_bad;

    // Channel whose word is driven after this edge, so the read mux is ready in time.
    always_comb begin
        rd_ch = slot_ch_q;
        if (frame_go) begin
            rd_ch = '0;
        end else if ((bit_cnt_q == '0) && (slot_ch_q != LastCh)) begin
            rd_ch = slot_ch_q + 1'b1;
        end
    end

    mcac_tdm_frame_buf #(
        .NUM_CH    (NUM_CH),
        .SLOT_W    (SLOT_W),
        .IDLE_CODE (IDLE_CODE)
    ) u_frame_buf (
        .clk_i      (clk_i),
        .rst_ni     (rst_ni),
        .swap_i     (frame_go),
        .wr_en_i    (wr_ok),
        .wr_ch_i    (wr_ch_i),
        .wr_data_i  (wr_data_i),
        .rd_ch_i    (rd_ch),
        .rd_word_o  (rd_word),
        .rd_valid_o (rd_valid)
    );

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q       <= IDLE;
            slot_ch_q     <= '0;
            bit_cnt_q     <= '0;
            tx_data_q     <= 1'b0;
            tx_oe_q       <= 1'b0;
            frame_start_q <= 1'b0;
            underrun_q    <= 1'b0;
            wr_err_q      <= 1'b0;
            fs_err_q      <= 1'b0;
        end else begin
            frame_start_q <= 1'b0;
            underrun_q    <= 1'b0;
            fs_err_q      <= 1'b0;
            wr_err_q      <= wr_bad;
            if (frame_go) begin
                fs_err_q      <= (state_q == SEND) && !frame_done;
                state_q       <= SEND;
                slot_ch_q     <= '0;
                bit_cnt_q     <= LastBit;
                tx_data_q     <= rd_word[SLOT_W-1];
                tx_oe_q       <= 1'b1;
                frame_start_q <= 1'b1;
                underrun_q    <= !rd_valid;
            end else if (bit_en_i && (state_q == SEND)) begin
                if (bit_cnt_q != '0) begin
                    bit_cnt_q <= bit_cnt_q - 1'b1;
                    tx_data_q <= rd_word[bit_cnt_q-1'b1];
                end else if (slot_ch_q != LastCh) begin
                    slot_ch_q  <= rd_ch;
                    bit_cnt_q  <= LastBit;
                    tx_data_q  <= rd_word[SLOT_W-1];
                    underrun_q <= !rd_valid;
                end else begin
                    state_q   <= IDLE;
                    slot_ch_q <= '0;
                    tx_data_q <= 1'b0;
                    tx_oe_q   <= 1'b0;
                end
            end
        end
    end

    assign tx_data_o     = tx_data_q;
    assign tx_oe_o       = tx_oe_q;
    assign frame_start_o = frame_start_q;
    assign slot_ch_o     = slot_ch_q;
    assign underrun_o    = underrun_q;
    assign wr_err_o      = wr_err_q;
    assign fs_err_o      = fs_err_q;

endmodule

// File: tb/tb_mcac_tdm_tx.sv
// Bench for mcac_tdm_tx: frame-level reference model plus directed and random stimulus.
module tb_mcac_tdm_tx;

    localparam int N   = 4;
    localparam int S   = 8;
    localparam int TOT = N * S;

    logic       clk_i = 1'b0;
    logic       rst_ni = 1'b0;
    logic       bit_en_i = 1'b0;
    logic       fs_i = 1'b0;
    logic       wr_en_i = 1'b0;
    logic [1:0] wr_ch_i = '0;
    logic [7:0] wr_data_i = '0;
    logic       tx_data_o, tx_oe_o, frame_start_o, underrun_o, wr_err_o, fs_err_o;
    logic [1:0] slot_ch_o;

    // Second instance with a non power-of-two channel count, used for write range errors.
    logic       w5_en = 1'b0;
    logic [2:0] w5_ch = '0;
    logic       tx5_data, tx5_oe, fs5_start, ur5, we5_err, fs5_err;
    logic [2:0] slot5;

    int total = 0;
    int bad = 0;
    int phase = 0;

    logic [31:0] cap;
    int          urn;
    int          urn5;

    always #5 clk_i = ~clk_i;

    mcac_tdm_tx #(.NUM_CH(N), .SLOT_W(S), .IDLE_CODE(8'hFF)) dut (
        .clk_i(clk_i), .rst_ni(rst_ni), .bit_en_i(bit_en_i), .fs_i(fs_i),
        .wr_en_i(wr_en_i), .wr_ch_i(wr_ch_i), .wr_data_i(wr_data_i),
        .tx_data_o(tx_data_o), .tx_oe_o(tx_oe_o), .frame_start_o(frame_start_o),
        .slot_ch_o(slot_ch_o), .underrun_o(underrun_o), .wr_err_o(wr_err_o),
        .fs_err_o(fs_err_o)
    );

    mcac_tdm_tx #(.NUM_CH(5), .SLOT_W(S), .IDLE_CODE(8'hFF)) dut5 (
        .clk_i(clk_i), .rst_ni(rst_ni), .bit_en_i(bit_en_i), .fs_i(fs_i),
        .wr_en_i(w5_en), .wr_ch_i(w5_ch), .wr_data_i(8'h00),
        .tx_data_o(tx5_data), .tx_oe_o(tx5_oe), .frame_start_o(fs5_start),
        .slot_ch_o(slot5), .underrun_o(ur5), .wr_err_o(we5_err),
        .fs_err_o(fs5_err)
    );

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            if (bad <= 40) $display("FAIL %s at %0t: got %h expected %h", nm, $time, act, exp);
        end
    endtask

    // One clock; bit_en strobes every 4th cycle and fs only takes effect on a strobe.
    task automatic step(input bit fs, input bit we, input logic [1:0] ch, input logic [7:0] d);
        @(negedge clk_i);
        bit_en_i  = (phase == 3);
        fs_i      = fs && (phase == 3);
        wr_en_i   = we;
        wr_ch_i   = ch;
        wr_data_i = d;
        w5_en     = ($urandom_range(0, 3) == 0);
        w5_ch     = 3'(5 + $urandom_range(0, 2));
        phase     = (phase + 1) % 4;
    endtask

    task automatic fs_pulse(input bit we, input logic [1:0] ch, input logic [7:0] d);
        while (phase != 3) step(1'b0, 1'b0, 2'd0, 8'h00);
        step(1'b1, we, ch, d);
    endtask

    task automatic idle_bits(input int n);
        repeat (4 * n) step(1'b0, 1'b0, 2'd0, 8'h00);
    endtask

    task automatic settle();
        step(1'b0, 1'b0, 2'd0, 8'h00);
    endtask

    // Reference model: "fill" is what the next frame will carry, "txf" what is on the wire.
    initial begin : model
        int          pos;
        logic [7:0]  fill_w [N];
        bit          fill_v [N];
        logic [7:0]  txf_w [N];
        bit          txf_v [N];
        logic [7:0]  word;
        bit          s_be, s_fs, s_we, s_w5;
        logic [1:0]  s_ch;
        logic [2:0]  s_ch5;
        logic [7:0]  s_d;
        bit          e_fs, e_ur, e_fe, e_oe, e_tx, e_we5;
        int          e_slot;
        pos = -1;
        for (int i = 0; i < N; i++) begin
            fill_v[i] = 0; txf_v[i] = 0; fill_w[i] = 8'h00; txf_w[i] = 8'h00;
        end
        cap = '0; urn = 0; urn5 = 0;
        forever begin
            @(posedge clk_i);
            s_be = bit_en_i; s_fs = fs_i; s_we = wr_en_i; s_ch = wr_ch_i; s_d = wr_data_i;
            s_w5 = w5_en; s_ch5 = w5_ch;
            #1;
            e_fs = 0; e_ur = 0; e_fe = 0; e_we5 = 0;
            if (!rst_ni) begin
                pos = -1;
                for (int i = 0; i < N; i++) begin
                    fill_v[i] = 0; txf_v[i] = 0;
                end
            end else begin
                e_we5 = s_w5 && (s_ch5 >= 3'd5);
                if (s_be && s_fs) begin
                    e_fe = (pos >= 0) && (pos < TOT - 1);
                    for (int i = 0; i < N; i++) begin
                        txf_w[i] = fill_w[i]; txf_v[i] = fill_v[i]; fill_v[i] = 0;
                    end
                    pos  = 0;
                    e_fs = 1;
                    e_ur = !txf_v[0];
                end else if (s_be && pos >= 0) begin
                    pos++;
                    if (pos == TOT) pos = -1;
                    else if (pos % S == 0) e_ur = !txf_v[pos / S];
                end
                if (s_we) begin
                    fill_w[s_ch] = s_d; fill_v[s_ch] = 1;
                end
            end
            e_oe   = (pos >= 0);
            e_slot = e_oe ? pos / S : 0;
            e_tx   = 1'b0;
            if (e_oe) begin
                word = txf_v[e_slot] ? txf_w[e_slot] : 8'hFF;
                e_tx = word[7 - pos % S];
            end
            chk("tx_oe", 32'(tx_oe_o), 32'(e_oe));
            chk("tx_data", 32'(tx_data_o), 32'(e_tx));
            chk("slot_ch", 32'(slot_ch_o), 32'(e_slot));
            chk("frame_start", 32'(frame_start_o), 32'(e_fs));
            chk("underrun", 32'(underrun_o), 32'(e_ur));
            chk("fs_err", 32'(fs_err_o), 32'(e_fe));
            chk("wr_err", 32'(wr_err_o), 32'd0);
            chk("wr_err5", 32'(we5_err), 32'(e_we5));
            if (!rst_ni) begin
                cap = '0; urn = 0; urn5 = 0;
            end else if (e_fs) begin
                cap = {31'b0, tx_data_o}; urn = int'(underrun_o); urn5 = int'(ur5);
            end else begin
                if (s_be && tx_oe_o) cap = {cap[30:0], tx_data_o};
                urn  += int'(underrun_o);
                urn5 += int'(ur5);
            end
        end
    end

    initial begin : watchdog
        #2_000_000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "timeout");
    end

    initial begin : stim
        repeat (3) @(negedge clk_i);
        chk("rst tx_data", 32'(tx_data_o), 32'd0);
        chk("rst tx_oe", 32'(tx_oe_o), 32'd0);
        chk("rst frame_start", 32'(frame_start_o), 32'd0);
        chk("rst slot_ch", 32'(slot_ch_o), 32'd0);
        chk("rst underrun", 32'(underrun_o), 32'd0);
        chk("rst wr_err", 32'(wr_err_o), 32'd0);
        chk("rst fs_err", 32'(fs_err_o), 32'd0);
        rst_ni = 1'b1;

        // First frame after reset: nothing written.
        fs_pulse(1'b0, 2'd0, 8'h00);
        idle_bits(32);
        settle();
        chk("idle frame bits", cap, 32'hFFFF_FFFF);
        chk("idle frame underruns", 32'(urn), 32'd4);
        chk("idle frame ends", 32'(tx_oe_o), 32'd0);
        chk("dut5 ignored writes", 32'(urn5), 32'd5);

        // Full frame followed by a back-to-back fs.
        step(1'b0, 1'b1, 2'd0, 8'hA5);
        step(1'b0, 1'b1, 2'd1, 8'h3C);
        step(1'b0, 1'b1, 2'd2, 8'h00);
        step(1'b0, 1'b1, 2'd3, 8'hFF);
        fs_pulse(1'b0, 2'd0, 8'h00);
        idle_bits(31);
        settle();
        chk("data frame bits", cap, 32'hA53C_00FF);
        chk("data frame underruns", 32'(urn), 32'd0);
        fs_pulse(1'b0, 2'd0, 8'h00);
        settle();
        chk("back-to-back no fs_err", 32'(fs_err_o), 32'd0);
        chk("back-to-back frame_start", 32'(frame_start_o), 32'd1);
        idle_bits(32);

        // Partially written frame.
        step(1'b0, 1'b1, 2'd2, 8'h81);
        fs_pulse(1'b0, 2'd0, 8'h00);
        idle_bits(31);
        settle();
        chk("partial frame bits", cap, 32'hFFFF_81FF);
        chk("partial frame underruns", 32'(urn), 32'd3);

        // Early fs after 13 bits.
        fs_pulse(1'b0, 2'd0, 8'h00);
        step(1'b0, 1'b1, 2'd1, 8'h96);
        repeat (4 * 12 - 1) step(1'b0, 1'b0, 2'd0, 8'h00);
        fs_pulse(1'b0, 2'd0, 8'h00);
        settle();
        chk("early fs_err", 32'(fs_err_o), 32'd1);
        chk("early slot_ch", 32'(slot_ch_o), 32'd0);
        chk("early tx_data msb", 32'(tx_data_o), 32'd1);
        idle_bits(31);
        settle();
        chk("resync frame bits", cap, 32'hFF96_FFFF);

        // Write on the exact frame-start cycle.
        idle_bits(2);
        fs_pulse(1'b1, 2'd3, 8'h5A);
        idle_bits(31);
        settle();
        chk("collision frame bits", cap, 32'hFFFF_FFFF);
        fs_pulse(1'b0, 2'd0, 8'h00);
        idle_bits(31);
        settle();
        chk("collision next frame", cap, 32'hFFFF_FF5A);
        chk("collision underruns", 32'(urn), 32'd3);
        idle_bits(2);

        // Reset mid-slot discards buffered words.
        step(1'b0, 1'b1, 2'd0, 8'h11);
        fs_pulse(1'b0, 2'd0, 8'h00);
        step(1'b0, 1'b1, 2'd1, 8'h22);
        idle_bits(5);
        @(negedge clk_i);
        rst_ni = 1'b0; bit_en_i = 1'b0; fs_i = 1'b0; wr_en_i = 1'b0; w5_en = 1'b0;
        #1;
        chk("async rst tx_oe", 32'(tx_oe_o), 32'd0);
        chk("async rst slot_ch", 32'(slot_ch_o), 32'd0);
        repeat (2) @(negedge clk_i);
        rst_ni = 1'b1;
        fs_pulse(1'b0, 2'd0, 8'h00);
        idle_bits(31);
        settle();
        chk("post-reset frame bits", cap, 32'hFFFF_FFFF);
        chk("post-reset underruns", 32'(urn), 32'd4);

        // Random writes and fs timing against the model.
        repeat (4000) begin
            step(($urandom_range(0, 39) == 0), ($urandom_range(0, 2) == 0),
                 2'($urandom_range(0, 3)), 8'($urandom));
        end
        idle_bits(40);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
